// File: rtl/cpu_run_monitor_pkg.sv
// Shared definitions for the CPU run monitor: controller state encoding and
// the verdict codes reported on fail_code.
package cpu_run_monitor_pkg;

  typedef enum logic [2:0] {
    ST_HOLD    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_e;

  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_MISMATCH = 2'd1;
  localparam logic [1:0] FC_NOSIG    = 2'd2;
  localparam logic [1:0] FC_TIMEOUT  = 2'd3;

  function automatic logic is_terminal(input state_e s);
    return (s == ST_PASS) || (s == ST_FAIL) || (s == ST_TIMEOUT);
  endfunction

endpackage

// File: rtl/cpu_run_monitor_sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones
// instead of wrapping. Clear has priority over enable.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;
  logic         w_at_max;

  assign w_at_max = &r_count;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_count <= '0;
    end else if (i_en && !w_at_max) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/cpu_run_monitor.sv
// Run controller for the MIPS core: holds the core in reset, lets it run while
// counting cycles/instructions and capturing the signature register, then
// latches a pass/fail/timeout verdict until restarted.
module cpu_run_monitor
  import cpu_run_monitor_pkg::*;
#(
  parameter int RESET_CYCLES = 10,
  parameter int CNT_W        = 32,
  parameter int TIMEOUT      = 100000,
  parameter int REG_AW       = 5,
  parameter int DATA_W       = 32,
  parameter int SIG_REG      = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              restart,
  input  logic              halt,
  input  logic              instr_retired,
  input  logic              rf_we,
  input  logic [REG_AW-1:0] rf_waddr,
  input  logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] expected,
  output logic              core_reset,
  output logic              running,
  output logic              done,
  output logic              pass,
  output logic [1:0]        fail_code,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  instr_count,
  output logic [DATA_W-1:0] signature
);

  localparam logic [REG_AW-1:0] SIG_IDX     = REG_AW'(SIG_REG);
  localparam logic              SIG_ENABLED = (SIG_REG != 0);
  localparam logic [CNT_W-1:0]  HOLD_LAST   = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]  RUN_LAST    = CNT_W'(TIMEOUT - 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [1:0]        r_fail_code;
  logic [1:0]        w_fail_code_nxt;
  logic [DATA_W-1:0] r_signature;
  logic              r_sig_valid;

  logic              w_in_hold;
  logic              w_in_run;
  logic              w_terminal;
  logic              w_restart_go;
  logic              w_capture;
  logic [DATA_W-1:0] w_sig_post;
  logic              w_valid_post;
  logic              w_hold_done;
  logic              w_timeout_hit;
  logic [CNT_W-1:0]  w_hold_cnt;
  logic [CNT_W-1:0]  w_cycle_cnt;
  logic [CNT_W-1:0]  w_instr_cnt;

  assign w_in_hold    = (r_state == ST_HOLD);
  assign w_in_run     = (r_state == ST_RUN);
  assign w_terminal   = is_terminal(r_state);
  assign w_restart_go = w_terminal && restart;

  // A capture in the halt cycle must feed the verdict, so compare post-capture.
  assign w_capture    = w_in_run && rf_we && SIG_ENABLED && (rf_waddr == SIG_IDX);
  assign w_sig_post   = w_capture ? rf_wdata : r_signature;
  assign w_valid_post = w_capture || r_sig_valid;

  assign w_hold_done   = w_in_hold && (w_hold_cnt == HOLD_LAST);
  assign w_timeout_hit = (w_cycle_cnt == RUN_LAST);

  // Hold counter restarts from zero whenever HOLD is (re)entered.
  sat_counter #(.W(CNT_W)) u_hold_cnt (
    .i_clk   (clk),
    .i_clr   (reset || !w_in_hold),
    .i_en    (w_in_hold),
    .o_count (w_hold_cnt)
  );

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .i_clk   (clk),
    .i_clr   (reset || w_restart_go),
    .i_en    (w_in_run),
    .o_count (w_cycle_cnt)
  );

  sat_counter #(.W(CNT_W)) u_instr_cnt (
    .i_clk   (clk),
    .i_clr   (reset || w_restart_go),
    .i_en    (w_in_run && instr_retired),
    .o_count (w_instr_cnt)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_fail_code_nxt = r_fail_code;
    unique case (r_state)
      ST_HOLD: begin
        if (w_hold_done) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (halt) begin
          if (!w_valid_post) begin
            w_state_nxt     = ST_FAIL;
            w_fail_code_nxt = FC_NOSIG;
          end else if (w_sig_post == expected) begin
            w_state_nxt     = ST_PASS;
            w_fail_code_nxt = FC_NONE;
          end else begin
            w_state_nxt     = ST_FAIL;
            w_fail_code_nxt = FC_MISMATCH;
          end
        end else if (w_timeout_hit) begin
          w_state_nxt     = ST_TIMEOUT;
          w_fail_code_nxt = FC_TIMEOUT;
        end
      end
      ST_PASS, ST_FAIL, ST_TIMEOUT: begin
        if (restart) begin
          w_state_nxt     = ST_HOLD;
          w_fail_code_nxt = FC_NONE;
        end
      end
      default: begin
        w_state_nxt     = ST_HOLD;
        w_fail_code_nxt = FC_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_HOLD;
      r_fail_code <= FC_NONE;
      r_signature <= '0;
      r_sig_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_fail_code <= w_fail_code_nxt;
      if (w_restart_go) begin
        r_signature <= '0;
        r_sig_valid <= 1'b0;
      end else if (w_capture) begin
        r_signature <= rf_wdata;
        r_sig_valid <= 1'b1;
      end
    end
  end

  // Core stays in reset outside RUN, which also freezes it after a verdict.
  assign core_reset  = !w_in_run;
  assign running     = w_in_run;
  assign done        = w_terminal;
  assign pass        = (r_state == ST_PASS);
  assign fail_code   = r_fail_code;
  assign cycle_count = w_cycle_cnt;
  assign instr_count = w_instr_cnt;
  assign signature   = r_signature;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Self-checking bench for cpu_run_monitor: directed and randomized runs scored
// against a per-cycle event model of the run rules.
module tb_cpu_run_monitor;

  localparam int TMO  = 50;
  localparam int RSTC = 10;
  localparam int MAXL = 128;

  logic        clk = 1'b0;
  logic        reset, restart, halt, instr_retired, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, expected;
  logic        core_reset, running, done, pass;
  logic [1:0]  fail_code;
  logic [31:0] cycle_count, instr_count, signature;
  logic        d0_core_reset, d0_running, d0_done, d0_pass;
  logic [1:0]  d0_fail_code;
  logic [31:0] d0_cycle_count, d0_instr_count, d0_signature;

  int n_checks = 0;
  int n_pass   = 0;

  bit          ir [MAXL];
  bit          we [MAXL];
  bit          hl [MAXL];
  bit          rs [MAXL];
  logic [4:0]  wa [MAXL];
  logic [31:0] wd [MAXL];

  int          m_end, m_cyc, m_ins;
  bit          m_pass;
  logic [1:0]  m_fc;
  logic [31:0] m_sig;

  always #5 clk = ~clk;

  cpu_run_monitor #(.RESET_CYCLES(RSTC), .TIMEOUT(TMO), .SIG_REG(2)) dut (
    .clk(clk), .reset(reset), .restart(restart), .halt(halt),
    .instr_retired(instr_retired), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .expected(expected), .core_reset(core_reset),
    .running(running), .done(done), .pass(pass), .fail_code(fail_code),
    .cycle_count(cycle_count), .instr_count(instr_count), .signature(signature)
  );

  cpu_run_monitor #(.RESET_CYCLES(RSTC), .TIMEOUT(TMO), .SIG_REG(0)) dut0 (
    .clk(clk), .reset(reset), .restart(restart), .halt(halt),
    .instr_retired(instr_retired), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .expected(expected), .core_reset(d0_core_reset),
    .running(d0_running), .done(d0_done), .pass(d0_pass), .fail_code(d0_fail_code),
    .cycle_count(d0_cycle_count), .instr_count(d0_instr_count), .signature(d0_signature)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    restart = 0; halt = 0; instr_retired = 0; rf_we = 0; rf_waddr = '0; rf_wdata = '0;
  endtask

  task automatic clear_stim();
    for (int k = 0; k < MAXL; k++) begin
      ir[k] = 0; we[k] = 0; hl[k] = 0; rs[k] = 0; wa[k] = '0; wd[k] = '0;
    end
  endtask

  task automatic write_reg(input int k, input int r, input logic [31:0] v);
    we[k] = 1; wa[k] = 5'(r); wd[k] = v;
  endtask

  // Reference: walk RUN cycles in order, applying the capture/halt/timeout rules.
  task automatic model(input int sreg);
    int          ins;
    logic [31:0] sig;
    bit          v;
    m_end = -1; ins = 0; sig = '0; v = 0; m_fc = 2'd0; m_pass = 0;
    for (int k = 0; k < MAXL; k++) begin
      if (ir[k]) ins++;
      if (we[k] && sreg != 0 && int'(wa[k]) == sreg) begin sig = wd[k]; v = 1; end
      if (hl[k]) begin
        m_end = k;
        if (!v) m_fc = 2'd2;
        else if (sig == expected) m_pass = 1;
        else m_fc = 2'd1;
      end else if (k == TMO - 1) begin
        m_end = k;
        m_fc  = 2'd3;
      end
      if (m_end >= 0) break;
    end
    m_cyc = m_end + 1; m_ins = ins; m_sig = sig;
  endtask

  task automatic play(input int len);
    for (int k = 0; k < len; k++) begin
      instr_retired = ir[k]; rf_we = we[k]; rf_waddr = wa[k]; rf_wdata = wd[k];
      halt = hl[k]; restart = rs[k];
      tick();
    end
    idle_inputs();
  endtask

  // Counts core_reset-high cycles until RUN; core inputs are noise meanwhile.
  task automatic enter_run(output int n);
    int guard;
    n = 0; guard = 0;
    while (!running && guard < 50) begin
      if (core_reset) n++;
      halt = 1'($urandom); instr_retired = 1'($urandom); rf_we = 1'($urandom);
      rf_waddr = 5'd2; rf_wdata = $urandom;
      tick();
      guard++;
    end
    idle_inputs();
    if (!running) begin
      n_checks++;
      $display("FAIL enter_run: running never rose within %0d cycles", guard);
    end
  endtask

  task automatic restart_to_run(output int n);
    restart = 1; tick(); restart = 0;
    enter_run(n);
  endtask

  task automatic test_reset();
    int n;
    idle_inputs(); expected = '0; reset = 1;
    tick(); tick();
    n_checks++; if ({core_reset, running, done, pass} !== 4'b1000) $display("FAIL reset_flags: got %b want 1000", {core_reset, running, done, pass}); else n_pass++;
    n_checks++; if (fail_code !== 2'd0) $display("FAIL reset_fc: got %0d want 0", fail_code); else n_pass++;
    n_checks++; if ({cycle_count, instr_count, signature} !== 96'd0) $display("FAIL reset_counts: got %h %h %h want 0", cycle_count, instr_count, signature); else n_pass++;
    reset = 0;
    enter_run(n);
    n_checks++; if (n !== RSTC) $display("FAIL reset_hold_len: got %0d want %0d", n, RSTC); else n_pass++;
    n_checks++; if ({running, core_reset} !== 2'b10) $display("FAIL reset_run_entry: got %b want 10", {running, core_reset}); else n_pass++;
    n_checks++; if (cycle_count !== 32'd0) $display("FAIL reset_cyc0: got %0d want 0", cycle_count); else n_pass++;
  endtask

  task automatic test_pass();
    clear_stim();
    write_reg(5, 2, 32'h2A);
    for (int k = 8; k < 15; k++) ir[k] = 1;
    hl[20] = 1; expected = 32'h2A;
    model(2); play(m_end + 1);
    n_checks++; if ({done, pass, core_reset, running} !== {1'b1, m_pass, 1'b1, 1'b0}) $display("FAIL pass_flags: got %b want %b", {done, pass, core_reset, running}, {1'b1, m_pass, 2'b10}); else n_pass++;
    n_checks++; if (fail_code !== m_fc) $display("FAIL pass_fc: got %0d want %0d", fail_code, m_fc); else n_pass++;
    n_checks++; if (cycle_count !== 32'(m_cyc)) $display("FAIL pass_cyc: got %0d want %0d", cycle_count, m_cyc); else n_pass++;
    n_checks++; if (instr_count !== 32'(m_ins)) $display("FAIL pass_ins: got %0d want %0d", instr_count, m_ins); else n_pass++;
    n_checks++; if (signature !== m_sig) $display("FAIL pass_sig: got %h want %h", signature, m_sig); else n_pass++;
  endtask

  task automatic test_restart();
    int n;
    restart = 1; tick(); restart = 0;
    n_checks++; if ({done, pass, running, core_reset} !== 4'b0001) $display("FAIL restart_flags: got %b want 0001", {done, pass, running, core_reset}); else n_pass++;
    n_checks++; if ({cycle_count, instr_count, signature, 30'd0, fail_code} !== 128'd0) $display("FAIL restart_clear: got %h %h %h %0d want 0", cycle_count, instr_count, signature, fail_code); else n_pass++;
    enter_run(n);
    n_checks++; if (n !== RSTC) $display("FAIL restart_hold_len: got %0d want %0d", n, RSTC); else n_pass++;
  endtask

  task automatic test_mismatch();
    int n;
    clear_stim();
    write_reg(3, 2, 32'h15); write_reg(6, 3, 32'h2A); hl[10] = 1; expected = 32'h2A;
    model(2); play(m_end + 1);
    n_checks++; if ({done, pass, fail_code} !== {1'b1, m_pass, m_fc}) $display("FAIL mismatch_verdict: got %b want %b", {done, pass, fail_code}, {1'b1, m_pass, m_fc}); else n_pass++;
    n_checks++; if (signature !== m_sig) $display("FAIL mismatch_sig: got %h want %h", signature, m_sig); else n_pass++;
    restart_to_run(n);
    clear_stim();
    write_reg(2, 3, 32'h2A); write_reg(4, 0, 32'h2A); hl[9] = 1;
    model(2); play(m_end + 1);
    n_checks++; if ({done, pass, fail_code} !== {1'b1, m_pass, m_fc}) $display("FAIL nosig_verdict: got %b want %b", {done, pass, fail_code}, {1'b1, m_pass, m_fc}); else n_pass++;
  endtask

  task automatic test_same_cycle();
    int n;
    restart_to_run(n);
    clear_stim();
    write_reg(4, 2, 32'h99); write_reg(7, 0, 32'h2A); write_reg(12, 2, 32'h2A);
    hl[12] = 1; ir[12] = 1; expected = 32'h2A;
    model(2); play(m_end + 1);
    n_checks++; if ({done, pass, fail_code} !== {1'b1, m_pass, m_fc}) $display("FAIL same_cycle_verdict: got %b want %b", {done, pass, fail_code}, {1'b1, m_pass, m_fc}); else n_pass++;
    n_checks++; if (instr_count !== 32'(m_ins)) $display("FAIL same_cycle_ins: got %0d want %0d", instr_count, m_ins); else n_pass++;
    model(0);
    n_checks++; if ({d0_done, d0_pass, d0_fail_code} !== {1'b1, m_pass, m_fc}) $display("FAIL sigreg0_verdict: got %b want %b", {d0_done, d0_pass, d0_fail_code}, {1'b1, m_pass, m_fc}); else n_pass++;
    n_checks++; if (d0_signature !== m_sig) $display("FAIL sigreg0_sig: got %h want %h", d0_signature, m_sig); else n_pass++;
  endtask

  task automatic test_timeout();
    int n;
    restart_to_run(n);
    clear_stim();
    for (int k = 0; k < MAXL; k++) ir[k] = 1'($urandom);
    write_reg(10, 2, 32'h2A); expected = 32'h2A;
    model(2); play(m_end + 1);
    n_checks++; if ({done, pass, fail_code} !== {1'b1, m_pass, m_fc}) $display("FAIL timeout_verdict: got %b want %b", {done, pass, fail_code}, {1'b1, m_pass, m_fc}); else n_pass++;
    n_checks++; if ({cycle_count, instr_count} !== {32'(m_cyc), 32'(m_ins)}) $display("FAIL timeout_counts: got %0d %0d want %0d %0d", cycle_count, instr_count, m_cyc, m_ins); else n_pass++;
    restart_to_run(n);
    hl[TMO - 1] = 1;
    model(2); play(m_end + 1);
    n_checks++; if ({done, pass, fail_code} !== {1'b1, m_pass, m_fc}) $display("FAIL timeout_halt_verdict: got %b want %b", {done, pass, fail_code}, {1'b1, m_pass, m_fc}); else n_pass++;
    n_checks++; if (cycle_count !== 32'(m_cyc)) $display("FAIL timeout_halt_cyc: got %0d want %0d", cycle_count, m_cyc); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int n, halt_at;
    logic [31:0] cyc_t, ins_t, sig_t;
    for (int it = 0; it < 8; it++) begin
      restart_to_run(n);
      clear_stim();
      halt_at = $urandom_range(3, 60);
      expected = 32'($urandom_range(0, 3));
      for (int k = 0; k < MAXL; k++) begin
        ir[k] = 1'($urandom); rs[k] = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 2) == 0) write_reg(k, $urandom_range(0, 3), 32'($urandom_range(0, 3)));
        hl[k] = (k == halt_at);
      end
      model(2); play(m_end + 1);
      n_checks++; if ({done, pass, fail_code} !== {1'b1, m_pass, m_fc}) $display("FAIL rand%0d_verdict: got %b want %b", it, {done, pass, fail_code}, {1'b1, m_pass, m_fc}); else n_pass++;
      n_checks++; if ({cycle_count, instr_count, signature} !== {32'(m_cyc), 32'(m_ins), m_sig}) $display("FAIL rand%0d_counts: got %0d %0d %h want %0d %0d %h", it, cycle_count, instr_count, signature, m_cyc, m_ins, m_sig); else n_pass++;
      cyc_t = 32'(m_cyc); ins_t = 32'(m_ins); sig_t = m_sig;
      model(0);
      n_checks++; if ({d0_done, d0_fail_code, d0_cycle_count} !== {1'b1, m_fc, 32'(m_cyc)}) $display("FAIL rand%0d_sigreg0: got %b %0d want %b %0d", it, {d0_done, d0_fail_code}, d0_cycle_count, {1'b1, m_fc}, m_cyc); else n_pass++;
      for (int j = 0; j < 5; j++) begin
        halt = 1'($urandom); instr_retired = 1; rf_we = 1; rf_waddr = 5'd2; rf_wdata = $urandom;
        tick();
      end
      idle_inputs();
      n_checks++; if ({done, cycle_count, instr_count, signature} !== {1'b1, cyc_t, ins_t, sig_t}) $display("FAIL rand%0d_frozen: got %0d %0d %h want %0d %0d %h", it, cycle_count, instr_count, signature, cyc_t, ins_t, sig_t); else n_pass++;
    end
  endtask

  task automatic test_reset_midrun();
    int n;
    restart_to_run(n);
    clear_stim();
    write_reg(3, 2, 32'hDEAD_BEEF);
    for (int k = 0; k < 30; k++) ir[k] = 1;
    rs[12] = 1;
    play(30);
    n_checks++; if ({running, cycle_count, signature} !== {1'b1, 32'd30, 32'hDEAD_BEEF}) $display("FAIL midrun_pre: got %b %0d %h want 1 30 deadbeef", running, cycle_count, signature); else n_pass++;
    reset = 1; tick(); reset = 0;
    n_checks++; if ({core_reset, running, done, pass, fail_code} !== 6'b100000) $display("FAIL midrun_flags: got %b want 100000", {core_reset, running, done, pass, fail_code}); else n_pass++;
    n_checks++; if ({cycle_count, instr_count, signature} !== 96'd0) $display("FAIL midrun_counts: got %h %h %h want 0", cycle_count, instr_count, signature); else n_pass++;
    enter_run(n);
    n_checks++; if (n !== RSTC) $display("FAIL midrun_hold_len: got %0d want %0d", n, RSTC); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_pass();
    test_restart();
    test_mismatch();
    test_same_cycle();
    test_timeout();
    test_back_to_back();
    test_reset_midrun();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_run_monitor.md
Name: cpu_run_monitor

Overview:
- Synthesizable run controller and monitor that sits beside the MIPS core `main` in simulation and FPGA bring-up.
- Sequences the core's reset for a programmable number of cycles, then lets the program run.
- While running, counts cycles and retired instructions, captures writes to a chosen signature register, and watches for a halt or a timeout.
- Reports a latched pass/fail verdict; replaces hand-written per-test stimulus and timing.

Parameters:
- RESET_CYCLES, 10: cycles core_reset is held high after each start; legal range 1 to 2^CNT_W-1.
- CNT_W, 32: width of the cycle and instruction counters.
- TIMEOUT, 100000: RUN cycles allowed before the TIMEOUT verdict; must be less than 2^CNT_W.
- REG_AW, 5: register-file write-address width.
- DATA_W, 32: register-file write-data width.
- SIG_REG, 2: register index whose writes are captured as the signature ($v0).

Ports:
- clk, input, 1: sole clock, rising edge.
- reset, input, 1: synchronous, active-high; clears all state and enters HOLD.
- restart, input, 1: single-cycle pulse; from a terminal state, begins a new run.
- halt, input, 1: core signals end of program (e.g. break/syscall decoded).
- instr_retired, input, 1: one instruction committed this cycle.
- rf_we, input, 1: core register-file write enable.
- rf_waddr, input, REG_AW: register-file write address.
- rf_wdata, input, DATA_W: register-file write data.
- expected, input, DATA_W: golden signature value; sampled only on halt.
- core_reset, output, 1: drives the core's reset.
- running, output, 1: high in RUN.
- done, output, 1: high in PASS, FAIL or TIMEOUT.
- pass, output, 1: high in PASS only.
- fail_code, output, 2: 0 = none/PASS, 1 = signature mismatch, 2 = no signature written, 3 = timeout.
- cycle_count, output, CNT_W: RUN cycles elapsed.
- instr_count, output, CNT_W: instructions retired in RUN.
- signature, output, DATA_W: last captured SIG_REG write value.

Behaviour:
- Reset values: state HOLD, hold counter 0, core_reset 1, running 0, done 0, pass 0, fail_code 0, both counts 0, signature 0, sig_valid 0.
- States: HOLD, RUN, PASS, FAIL, TIMEOUT. All outputs are registered or a direct state decode; there is no combinational path from any input to any output.
- HOLD:
  - core_reset = 1; hold counter increments each cycle.
  - When the counter equals RESET_CYCLES-1, next state is RUN. core_reset is therefore high for exactly RESET_CYCLES cycles after reset or restart deasserts.
  - halt, instr_retired and rf_we are ignored.
- RUN:
  - core_reset = 0 and running = 1.
  - cycle_count increments every cycle, and instr_count increments when instr_retired is high. Both saturate at all-ones.
  - Signature capture: when rf_we is high, rf_waddr == SIG_REG and SIG_REG != 0, then signature <= rf_wdata and sig_valid <= 1. A later write overwrites the earlier one.
- Verdict on halt (halt high in RUN):
  - sig_valid = 0 → FAIL, fail_code 2.
  - signature == expected → PASS.
  - otherwise → FAIL, fail_code 1.
  - A signature write in the same cycle as halt is included: the comparison uses the post-capture value, i.e. rf_wdata when a capture occurs.
  - instr_retired in the halt cycle is counted.
- Timeout: cycle_count == TIMEOUT-1 in RUN with no halt → TIMEOUT, fail_code 3. If halt and the timeout condition occur in the same cycle, halt wins.
- Terminal states (PASS, FAIL, TIMEOUT):
  - core_reset = 1, which freezes the core.
  - done = 1; counters, signature, pass and fail_code hold their values.
  - restart → HOLD, clearing the hold counter, both counts, signature, sig_valid and fail_code.
- restart while in HOLD or RUN is ignored.
- reset has priority over everything, in every state, mid-run included.

Decomposition:
- Shared package/header: state encoding (3 bits) and fail_code constants (FC_NONE, FC_MISMATCH, FC_NOSIG, FC_TIMEOUT).
- One natural sub-module, sat_counter: a parametrised width, clear and enable saturating counter, instanced three times (hold, cycle, instr).
- The FSM and signature capture stay in the top level.

Test Plan:
- Reset sequencing: reset for 2 cycles, then release → core_reset high exactly 10 cycles, then running = 1 on cycle 11; cycle_count = 0 at RUN entry.
- Pass path: write $2 = 0x0000_002A at RUN cycle 5, assert instr_retired for 7 cycles, halt at cycle 20 with expected = 0x2A → PASS, pass = 1, instr_count = 7, cycle_count = 21, core_reset = 1.
- Mismatch and writes to other registers: write $2 = 0x15, write $3 = 0x2A, then halt with expected = 0x2A → FAIL, fail_code 1, signature = 0x15. With no $2 write at all → fail_code 2.
- Same-cycle write and halt: rf_we to $2 with 0x2A on the halt cycle, expected = 0x2A → PASS. Also with SIG_REG = 0, writes are never captured → fail_code 2.
- Timeout: TIMEOUT = 50 and no halt → TIMEOUT after cycle_count reaches 49, fail_code 3. With halt on that same cycle → PASS/FAIL verdict instead.
- Restart and reset mid-run:
  - restart pulse in RUN → no effect.
  - restart in PASS → HOLD, counts and signature cleared, full 10-cycle reset again.
  - reset asserted at RUN cycle 30 → HOLD with all outputs at reset values on the next edge.
